// File: rtl/fir_pkg.sv
// Shared definitions for the 16-tap FIR filter.
// Holds tap count, datapath widths and the output saturation helper
// used by fir and fir_tap_line.
package fir_pkg;

    localparam int TAPS   = 16;
    localparam int DATA_W = 16;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 36;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

    // Clamp the wide accumulator to the signed 16-bit output range.
    function automatic logic signed [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] acc);
        logic signed [DATA_W-1:0] res;
        if (acc > SAT_MAX) begin
            res = 16'sh7FFF;
        end else if (acc < SAT_MIN) begin
            res = 16'sh8000;
        end else begin
            res = acc[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_tap_line.sv
// 16-entry shift register with enable, used for both the sample line
// and the coefficient line of the FIR.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset, clears every entry
//   en   - shift enable
//   din  - value entering at the top entry (taps[TAPS-1])
//   taps - all entries; on a shift taps[i] takes taps[i+1]
module fir_tap_line
    import fir_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [DATA_W-1:0]      din,
    output logic [TAPS-1:0][DATA_W-1:0]   taps
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps <= '0;
        end else if (en) begin
            taps <= {din, taps[TAPS-1:1]};
        end
    end

endmodule

// File: rtl/fir.sv
// 16-tap direct-form FIR filter with a shared sample/coefficient bus.
// Ports:
//   clk       - sole clock, rising edge
//   rst       - asynchronous active-high reset
//   wind      - shift data into the sample line, no output
//   load      - shift data into the coefficient line
//   in_valid  - shift data into the sample line and launch one result
//   data      - signed 16-bit sample/coefficient bus
//   out_valid - one-cycle pulse per launched result, 2 cycles after in_valid
//   out       - saturated signed 16-bit result, held between pulses
module fir
    import fir_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wind,
    input  logic                      load,
    input  logic                      in_valid,
    input  logic signed [DATA_W-1:0]  data,
    output logic                      out_valid,
    output logic signed [DATA_W-1:0]  out
);

    logic [TAPS-1:0][DATA_W-1:0] d_line;
    logic [TAPS-1:0][DATA_W-1:0] w_line;

    logic w_en;
    logic d_en;
    logic accept;

    logic                     vld_p0;
    logic signed [PROD_W-1:0] prod_p1 [TAPS];
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  acc_p1;

    // load outranks wind, wind outranks in_valid; only one strobe acts.
    assign w_en   = load;
    assign d_en   = !load && (wind || in_valid);
    assign accept = !load && !wind && in_valid;

    fir_tap_line u_d_line (
        .clk  (clk),
        .rst  (rst),
        .en   (d_en),
        .din  (data),
        .taps (d_line)
    );

    fir_tap_line u_w_line (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .din  (data),
        .taps (w_line)
    );

    // Stage p0: sample line updated, launch flag registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
        end
    end

    // Stage p1: products captured, so later wind/load cannot disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                prod_p1[i] <= '0;
            end
        end else begin
            vld_p1 <= vld_p0;
            for (int i = 0; i < TAPS; i++) begin
                prod_p1[i] <= $signed(d_line[i]) * $signed(w_line[i]);
            end
        end
    end

    always_comb begin
        acc_p1 = '0;
        for (int i = 0; i < TAPS; i++) begin
            acc_p1 = acc_p1 + ACC_W'(prod_p1[i]);
        end
    end

    // Stage p2: saturated result and valid pulse registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else begin
            out_valid <= vld_p1;
            if (vld_p1) begin
                out <= sat(acc_p1);
            end
        end
    end

endmodule

// File: tb/tb_fir.sv
module tb_fir;

    logic        clk;
    logic        rst;
    logic        wind;
    logic        load;
    logic        in_valid;
    logic [15:0] data;
    logic        out_valid;
    logic [15:0] out;

    typedef struct {
        logic [15:0] value;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;

    fir dut (
        .clk       (clk),
        .rst       (rst),
        .wind      (wind),
        .load      (load),
        .in_valid  (in_valid),
        .data      (data),
        .out_valid (out_valid),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got == want) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Monitor: every presented result is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_value"}, int'(out), int'(e.value));
                chk({e.name, "_latency"}, cyc, e.cyc);
            end
        end
    end

    // Drive one cycle of strobes; optionally record the expected result.
    task automatic step(input logic ld, input logic wd, input logic iv,
                        input logic [15:0] dat, input bit push,
                        input logic [15:0] expv, input string name);
        exp_t e;
        load     = ld;
        wind     = wd;
        in_valid = iv;
        data     = dat;
        @(posedge clk);
        #1;
        if (push) begin
            e.value = expv;
            e.cyc   = cyc + 2;
            e.name  = name;
            q.push_back(e);
        end
        load     = 1'b0;
        wind     = 1'b0;
        in_valid = 1'b0;
        data     = 16'h0000;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, "");
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 0;
        while (q.size() != 0 && budget < 10) begin
            idle(1);
            budget++;
        end
        chk({name, "_drained"}, q.size(), 0);
        if (q.size() != 0) q.delete();
    endtask

    logic [15:0] burst_exp [6];

    initial begin
        burst_exp[0] = 16'd1616;
        burst_exp[1] = 16'd1721;
        burst_exp[2] = 16'd1812;
        burst_exp[3] = 16'd1890;
        burst_exp[4] = 16'd1956;
        burst_exp[5] = 16'd2011;

        rst = 1'b1; wind = 1'b0; load = 1'b0; in_valid = 1'b0; data = 16'h0;
        #12;
        chk("reset_out", int'(out), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        // load and wind together: only coefficients move
        for (int i = 1; i <= 16; i++) step(1'b1, 1'b1, 1'b0, 16'(i), 1'b0, 16'h0, "");
        step(1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 16'd0, "priority_zero");
        drain("priority");

        // single sample, then a wind right behind it
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 16'(i), 1'b0, 16'h0, "");
        step(1'b0, 1'b0, 1'b1, 16'd16, 1'b1, 16'd1616, "single_1616");
        step(1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 16'h0, "");
        drain("single");

        // in_valid masked by wind produces nothing
        step(1'b0, 1'b1, 1'b1, 16'd7, 1'b0, 16'h0, "");
        idle(4);

        // back-to-back burst
        for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 16'(i), 1'b0, 16'h0, "");
        for (int n = 0; n < 6; n++)
            step(1'b0, 1'b0, 1'b1, 16'd16, 1'b1, burst_exp[n], $sformatf("burst%0d", n));
        drain("burst");

        // saturation positive then negative
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 1'b0, 16'h7FFF, 1'b0, 16'h0, "");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h7FFF, 1'b0, 16'h0, "");
        step(1'b0, 1'b0, 1'b1, 16'h7FFF, 1'b1, 16'h7FFF, "sat_pos");
        drain("sat_pos");
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 16'h8000, 1'b0, 16'h0, "");
        step(1'b0, 1'b0, 1'b1, 16'h8000, 1'b1, 16'h8000, "sat_neg");
        drain("sat_neg");
        chk("out_holds", int'(out), 32'h8000);

        // reset one cycle after in_valid discards the computation
        step(1'b0, 1'b0, 1'b1, 16'd1, 1'b0, 16'h0, "");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_out", int'(out), 0);
        chk("async_rst_out_valid", int'(out_valid), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("no_stray_valid%0d", i), int'(out_valid), 0);
        end

        // cleared coefficients give zero
        step(1'b0, 1'b0, 1'b1, 16'd5, 1'b1, 16'd0, "post_rst_zero");
        drain("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
